// File: rtl/ibtida_loader_pkg.sv
// ibtida_loader_pkg
// Shared types and constants for the UART program loader.
//   loader_state_t : top-level loader FSM states
//   rx_state_t     : byte receiver FSM states
//   EOP_WORD_DEF   : default end-of-program marker (never written to memory)
//   BIT_CNT_W      : bit-period counter width for the default baud divisor
//   bit_cnt_w()    : same width for any CLKS_PER_BIT
package ibtida_loader_pkg;

  typedef enum logic [1:0] {
    L_RESET,
    L_RECV,
    L_WRITE,
    L_DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  localparam logic [31:0] EOP_WORD_DEF     = 32'h0000_0FFF;
  localparam int          CLKS_PER_BIT_DEF = 87;
  localparam int          BIT_CNT_W        = $clog2(CLKS_PER_BIT_DEF);

  // Counter only ever holds 0..CLKS_PER_BIT-1, so clog2 is always wide enough.
  function automatic int bit_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Ports:
//   i_clk        in   clock
//   i_srst       in   synchronous active-high reset
//   i_rx         in   serial input, idle high
//   o_byte_valid out  1-cycle pulse, o_byte_data holds the received byte
//   o_byte_data  out  received byte (LSB first on the wire)
//   o_frame_err  out  1-cycle pulse when the stop bit samples low
module uart_rx_byte
  import ibtida_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1, r_sync2;
  logic             r_armed;
  rx_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid, r_ferr;
  logic             w_tick;

  // Start bit is re-checked half a bit in; every later sample is a full bit apart.
  assign w_tick = (r_state == R_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE:  if (r_armed && !r_sync2) w_state_next = R_START;
      R_START: if (w_tick) w_state_next = r_sync2 ? R_IDLE : R_DATA;
      R_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_next = R_STOP;
      R_STOP:  if (w_tick) w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_armed <= 1'b0;
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      if (r_state == R_IDLE) begin
        r_cnt <= '0;
        r_bit <= '0;
        // After a frame (especially a bad one) the line must be seen high
        // before a new start bit is accepted.
        if (r_sync2) r_armed <= 1'b1;
      end else if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == R_DATA) && w_tick) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end

      if ((r_state == R_STOP) && w_tick) begin
        r_armed <= 1'b0;
        if (r_sync2) r_valid <= 1'b1;
        else         r_ferr  <= 1'b1;
      end
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// Boot loader: receives UART bytes, packs little-endian 32-bit words and
// writes them to sequential instruction-memory addresses, holding the core
// in reset until the end-of-program word arrives.
// Ports:
//   wb_clk_i      in   clock
//   wb_rst_i      in   synchronous active-high reset
//   rx_i          in   UART serial input, idle high
//   ready_o       out  loader accepting bytes
//   imem_we_o     out  one-cycle write strobe
//   imem_addr_o   out  word address
//   imem_wdata_o  out  write data
//   core_rst_o    out  core reset, high until loading completes
//   done_o        out  end-of-program seen (sticky)
//   err_o         out  framing error or overflow seen (sticky)
module uart_prog_loader
  import ibtida_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] EOP_WORD     = EOP_WORD_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o
);

  logic          w_byte_valid;
  logic [7:0]    w_byte_data;
  logic          w_frame_err;

  loader_state_t     r_state, w_state_next;
  logic              r_boot;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_ins;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last_byte;
  logic              w_is_eop;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (wb_clk_i),
    .i_srst      (wb_rst_i),
    .i_rx        (rx_i),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  // Word as it would look with the incoming byte dropped into lane r_bcnt;
  // lets the EOP compare see the complete word in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_word_ins[8*gi +: 8] = (r_bcnt == 2'(gi)) ? w_byte_data : r_word[8*gi +: 8];
    end
  endgenerate

  assign w_last_byte = (r_state == L_RECV) && w_byte_valid && (r_bcnt == 2'd3);
  assign w_is_eop    = (w_word_ins == EOP_WORD);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      L_RESET: if (!r_boot) w_state_next = L_RECV;
      // r_full: memory already filled, so any further data word ends loading.
      L_RECV:  if (w_last_byte) w_state_next = (w_is_eop || r_full) ? L_DONE : L_WRITE;
      L_WRITE: w_state_next = L_RECV;
      L_DONE:  w_state_next = L_DONE;
      default: w_state_next = L_RESET;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= L_RESET;
      r_boot  <= 1'b1;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      // r_boot stretches L_RESET to one full cycle after reset release.
      r_boot  <= 1'b0;

      if (r_state == L_RECV) begin
        if (w_frame_err) begin
          r_err  <= 1'b1;
          r_bcnt <= '0;
        end else if (w_byte_valid) begin
          r_word <= w_word_ins;
          r_bcnt <= r_bcnt + 2'd1;
          if (w_last_byte && !w_is_eop && r_full) r_err <= 1'b1;
        end
      end

      if (r_state == L_WRITE) begin
        r_addr <= r_addr + 1'b1;
        if (&r_addr) r_full <= 1'b1;
      end
    end
  end

  assign ready_o      = (r_state == L_RECV) || (r_state == L_WRITE);
  assign imem_we_o    = (r_state == L_WRITE);
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_word;
  assign core_rst_o   = (r_state != L_DONE);
  assign done_o       = (r_state == L_DONE);
  assign err_o        = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;
  localparam logic [31:0] EOP = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          ready_o, imem_we_o, core_rst_o, done_o, err_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0]   word;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_addr_after;
    logic          exp_done;
  } vec_t;

  wr_t wr_q[$];

  // reference model state
  logic [7:0] m_bytes[$];
  wr_t        m_exp[$];
  int         m_addr;
  bit         m_done, m_err;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .EOP_WORD    (EOP)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_i        (rx),
    .ready_o     (ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .core_rst_o  (core_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // write monitor: sampled on the falling edge
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] next_addr;
  always @(negedge clk) begin
    if (!rst && imem_we_o) begin
      wr_q.push_back('{imem_addr_o, imem_wdata_o});
      chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
    end
    if (!rst && prev_we && prev_addr != '1) begin
      next_addr = prev_addr + 1'b1;
      chk("addr_incr", imem_addr_o, next_addr);
    end
    prev_we   = imem_we_o;
    prev_addr = imem_addr_o;
  end

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_bytes.delete();
    m_exp.delete();
    m_addr = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    logic [31:0] w;
    if (m_done) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == EOP) m_done = 1;
      else if (m_addr >= (1 << AW)) begin
        m_err  = 1;
        m_done = 1;
      end else begin
        m_exp.push_back('{4'(m_addr), w});
        m_addr++;
      end
    end
  endtask

  task automatic m_ferr();
    if (!m_done) begin
      m_err = 1;
      m_bytes.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic tx(input logic [7:0] b);
    send_byte(b, 1'b1);
    m_byte(b);
  endtask

  task automatic tx_ferr(input logic [7:0] b);
    send_byte(b, 1'b0);
    m_ferr();
  endtask

  task automatic tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_we", imem_we_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_wdata", imem_wdata_o, 0);
    chk("rst_core_rst", core_rst_o, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_edge1_ready", ready_o, 0);
    @(negedge clk);
    chk("rel_edge2_ready", ready_o, 1);
    chk("rel_core_rst", core_rst_o, 1);
    m_reset();
    wr_q.delete();
  endtask

  task automatic cmp_all(input string tag);
    wr_t a, e;
    chk({tag, "_nwr"}, wr_q.size(), m_exp.size());
    while (wr_q.size() > 0 && m_exp.size() > 0) begin
      a = wr_q.pop_front();
      e = m_exp.pop_front();
      chk({tag, "_wr_addr"}, a.addr, e.addr);
      chk({tag, "_wr_data"}, a.data, e.data);
    end
    wr_q.delete();
    m_exp.delete();
    chk({tag, "_done"}, done_o, m_done);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_core_rst"}, core_rst_o, !m_done);
    chk({tag, "_ready"}, ready_o, !m_done);
    if (!m_done) chk({tag, "_addr"}, imem_addr_o, 4'(m_addr));
  endtask

  vec_t tbl[4];

  initial begin
    wr_t w;
    logic [31:0] rw;
    int r;

    tbl[0] = '{32'hDEADBEEF, 1'b1, 4'd0, 4'd1, 1'b0};
    tbl[1] = '{32'h00000093, 1'b1, 4'd1, 4'd2, 1'b0};
    tbl[2] = '{32'h12345678, 1'b1, 4'd2, 4'd3, 1'b0};
    tbl[3] = '{32'h00000FFF, 1'b0, 4'd0, 4'd3, 1'b1};

    // reset release and idle
    do_reset();
    repeat (20) @(negedge clk);
    chk("idle_nwr", wr_q.size(), 0);
    chk("idle_core_rst", core_rst_o, 1);
    chk("idle_we", imem_we_o, 0);

    // single word then EOP, then bytes after done are ignored
    tx(8'h13); tx(8'h00); tx(8'h00); tx(8'h00);
    cmp_all("single");
    tx(8'hFF); tx(8'h0F); tx(8'h00);
    chk("eop_partial_done", done_o, 0);
    tx(8'h00);
    cmp_all("eop");
    tx_word(32'h01020304);
    cmp_all("after_done");

    // table-driven: three words then EOP
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tx_word(tbl[i].word);
      chk($sformatf("tbl%0d_nwr", i), wr_q.size(), tbl[i].exp_we);
      if (tbl[i].exp_we && wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk($sformatf("tbl%0d_addr", i), w.addr, tbl[i].exp_addr);
        chk($sformatf("tbl%0d_data", i), w.data, tbl[i].word);
      end
      wr_q.delete();
      chk($sformatf("tbl%0d_done", i), done_o, tbl[i].exp_done);
      chk($sformatf("tbl%0d_addr_after", i), imem_addr_o, tbl[i].exp_addr_after);
    end
    m_exp.delete();
    cmp_all("tbl_end");

    // framing error after two good bytes, then recovery
    do_reset();
    tx(8'h11); tx(8'h22);
    tx_ferr(8'h33);
    cmp_all("ferr");
    tx(8'hAA); tx(8'hBB); tx(8'hCC); tx(8'hDD);
    cmp_all("ferr_recover");

    // reset mid-byte, then clean load from addr 0
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    do_reset();
    repeat (CPB * 12) @(negedge clk);
    tx_word(32'hCAFE0001);
    cmp_all("after_midrst");

    // glitch: 2-cycle low pulse must not produce a byte
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_nowrite", wr_q.size(), 0);
    tx_word(32'h5A5A0F0F);
    cmp_all("glitch_align");

    // overflow: 16 words fill memory, 17th ends loading with an error
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rw = $urandom;
      if (rw == EOP) rw = rw ^ 32'h1;
      tx_word(rw);
    end
    cmp_all("fill16");
    rw = 32'h0BADF00D;
    tx_word(rw);
    cmp_all("overflow");

    // randomized streams against the model
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int ev = 0; ev < 24; ev++) begin
        r = $urandom_range(0, 99);
        if (r < 10) tx_ferr(8'($urandom));
        else if (r < 14) tx_word(EOP);
        else tx(8'($urandom));
        if (ev % 8 == 7) cmp_all($sformatf("rnd%0d_%0d", round, ev));
      end
      cmp_all($sformatf("rnd%0d_end", round));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Boot-time program loader for the Ibtida user project. It sits directly downstream of the off-chip serial programmer on `mprj_io[5]` and drives the ready flag on `mprj_io[37]`. It receives 8N1 UART bytes, assembles little-endian 32-bit words and writes them sequentially into instruction memory. It holds the core in reset until the end-of-program marker arrives.

## Interface
Parameters:
- `CLKS_PER_BIT`, 87: `wb_clk_i` cycles per UART bit; must be ≥ 4.
- `ADDR_W`, 8: instruction memory word-address width.
- `EOP_WORD`, 32'h0000_0FFF: end-of-program marker; it is never written to memory.

Ports:
- `wb_clk_i`  in  1  — single clock.
- `wb_rst_i`  in  1  — reset, synchronous, active-high.
- `rx_i`  in  1  — UART serial input; idle high.
- `ready_o`  out  1  — loader accepting bytes; routed to `mprj_io[37]`.
- `imem_we_o`  out  1  — one-cycle write strobe.
- `imem_addr_o`  out  ADDR_W  — word address.
- `imem_wdata_o`  out  32  — write data.
- `core_rst_o`  out  1  — core reset; high until loading completes.
- `done_o`  out  1  — EOP received; sticky.
- `err_o`  out  1  — framing error or memory overflow seen; sticky.

## Operation
- **Input sync:** `rx_i` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- **Byte receiver** (sub-module) runs its own FSM: R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE → R_START on synchronized `rx` = 0.
  - R_START re-samples at CLKS_PER_BIT/2 (integer division).
    - If the line is high, treat it as a glitch and return to R_IDLE.
    - Otherwise go to R_DATA.
  - R_DATA samples 8 bits, LSB first, one every CLKS_PER_BIT cycles from the start-bit midpoint.
  - R_STOP samples the stop bit.
    - Stop bit = 1: pulse `byte_valid` for 1 cycle with `byte_data`.
    - Stop bit = 0: pulse `frame_err` and produce no byte.
  - After R_STOP the receiver returns to R_IDLE and waits for `rx` high before re-arming.
- **Loader FSM** has four states: L_RESET → L_RECV → L_WRITE → L_DONE.
  - L_RESET lasts one cycle after reset deasserts, then moves to L_RECV.
  - L_RECV:
    - Each byte shifts into the word: byte k goes to bits [8k+7:8k], with k = 0..3 as a 2-bit counter.
    - On the 4th byte, go to L_DONE if word == EOP_WORD, else go to L_WRITE.
  - L_WRITE:
    - Asserts `imem_we_o` for exactly 1 cycle with the current address and data.
    - Then increments the address and returns to L_RECV.
  - L_DONE is terminal until reset.
    - Drives `core_rst_o` = 0, `done_o` = 1, `ready_o` = 0.
    - Ignores further bytes.
- **Framing error:** sets `err_o`, discards the partial word (byte counter cleared) and stays in L_RECV.
- **Overflow:** a word that completes while the address is 2^ADDR_W−1 is written normally. The next non-EOP word sets `err_o`, is not written, and the FSM goes to L_DONE.
- `ready_o` = 1 only in L_RECV and L_WRITE.

## Timing
- **Reset values:**
  - `ready_o`, `imem_we_o`, `done_o`, `err_o` = 0.
  - `imem_addr_o` = 0, `imem_wdata_o` = 0.
  - `core_rst_o` = 1.
  - Both FSMs idle; byte counter = 0.
- `ready_o` rises on the 2nd `wb_clk_i` edge after `wb_rst_i` falls.
- **Byte latency:** `byte_valid` pulses 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling start edge reaches `rx_i`, ±1 cycle.
- **Write latency:** `imem_we_o` is high the cycle after the 4th `byte_valid`. Address and data are stable during that cycle and `imem_addr_o` updates the cycle after it.
- **EOP latency:** `core_rst_o` falls and `done_o` rises the cycle after the EOP word's 4th `byte_valid`.
- **Bytes arriving during L_WRITE:** cannot occur, since the minimum byte spacing is 9·CLKS_PER_BIT ≥ 36 cycles and L_WRITE lasts 1 cycle. No buffering is required.
- **Reset mid-byte or mid-word:** everything returns to reset values on the next edge. The partial word is lost and the address returns to 0.
- `wb_rst_i` has priority over all other events in the same cycle.

## Structure
- Package `ibtida_loader_pkg` holds:
  - the loader and receiver state enums;
  - the `EOP_WORD` default;
  - a localparam for the bit-counter width, $clog2(CLKS_PER_BIT).
- Sub-module `uart_rx_byte` contains the synchronizer, the receiver FSM, `byte_valid`, `byte_data` and `frame_err`.
- The top level holds the loader FSM, word assembly and address counter.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and ADDR_W = 4.
- **Reset release:** `ready_o` = 1 two cycles after reset release. `core_rst_o` = 1, `imem_we_o` = 0 throughout idle.
- **Single word + EOP:**
  - Send bytes 13 00 00 00 → one write, `addr` 0, `data` 32'h0000_0013.
  - Then send FF 0F 00 00 → `core_rst_o` = 0, `done_o` = 1, no further write.
- **Three words** 32'hDEADBEEF, 32'h00000093, 32'h12345678 → writes at addrs 0, 1, 2 in order; `imem_addr_o` = 3 afterwards.
- **Framing error:**
  - A byte with stop bit = 0 after 2 good bytes → `err_o` = 1, no write.
  - The next 4 bytes AA BB CC DD → write 32'hDDCCBBAA at addr 0.
- **Overflow:**
  - 16 words → writes at addrs 0..15.
  - A 17th non-EOP word → no write, `err_o` = 1, `done_o` = 1.
- **Glitch and reset:**
  - A 2-cycle low pulse on `rx_i` → no `byte_valid`.
  - `wb_rst_i` asserted mid-byte → all outputs return to reset values. A following clean load starts at addr 0.
